// File: rtl/pattern_scan_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : pattern_scan_arbiter_if
// Description : Requester and response handshake bundle for pattern_scan_arbiter.
//               The PATTERN_FIRST_POS_EN macro adds resp_first_pos and resp_none.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps

interface pattern_scan_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
);
    localparam int POS_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic              req0_valid;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              resp_valid;
    logic              resp_ready;
    logic              resp_id;
    logic [CNT_W-1:0]  resp_count;
`ifdef PATTERN_FIRST_POS_EN
    logic [POS_W-1:0]  resp_first_pos;
    logic              resp_none;
`endif

    // Arbiter side
    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, resp_ready,
`ifdef PATTERN_FIRST_POS_EN
        output resp_first_pos, resp_none,
`endif
        output req0_ready, req1_ready, resp_valid, resp_id, resp_count
    );

    // Requester / consumer side
    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, resp_ready,
`ifdef PATTERN_FIRST_POS_EN
        input  resp_first_pos, resp_none,
`endif
        input  req0_ready, req1_ready, resp_valid, resp_id, resp_count
    );
endinterface

`default_nettype wire

// File: rtl/pattern_scan_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pattern_scan_arbiter
// Description : Round-robin shares one serial pattern matcher between two
//               requesters and returns the saturating match count.
//               Optional macro PATTERN_FIRST_POS_EN reports first-match position.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps

module pattern_scan_arbiter #(
    parameter int               DATA_W  = 8,
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int               CNT_W   = 4
) (
    input  wire logic               clk,
    input  wire logic               reset_n,
    pattern_scan_arbiter_if.slave   bus,
    output logic                    busy,
    output logic                    ser_bit,
    output logic                    match_pulse
);

    localparam int               IDX_W           = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] C_IDX_LAST      = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] C_IDX_MATCH_MAX = IDX_W'(DATA_W - PAT_W);
    localparam logic [CNT_W-1:0] C_CNT_MAX       = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [DATA_W-1:0] r_word;
    logic [IDX_W-1:0]  r_idx;
    logic [PAT_W-2:0]  r_hist;
    logic [CNT_W-1:0]  r_count;
    logic              r_last_grant;
    logic              r_resp_id;
`ifdef PATTERN_FIRST_POS_EN
    logic [IDX_W-1:0]  r_first_pos;
    logic              r_found;
`endif

    logic              w_grant0;
    logic              w_grant1;
    logic              w_take;
    logic              w_ser_bit;
    logic [PAT_W-1:0]  w_window;
    logic              w_match;

    // Round-robin: on a tie the requester that was not served last wins.
    assign w_grant0 = bus.req0_valid && (!bus.req1_valid ||  r_last_grant);
    assign w_grant1 = bus.req1_valid && (!bus.req0_valid || !r_last_grant);
    assign w_take   = (r_state == S_IDLE) && (w_grant0 || w_grant1);

    assign w_ser_bit = (r_state == S_SHIFT) ? r_word[r_idx] : 1'b0;
    assign w_window  = {r_hist, w_ser_bit};
    // The window only holds PAT_W real bits once idx has dropped to DATA_W-PAT_W.
    assign w_match   = (r_state == S_SHIFT) && (r_idx <= C_IDX_MATCH_MAX)
                       && (w_window == PATTERN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_take) begin
                    w_next_state = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_idx == '0) begin
                    w_next_state = S_REPORT;
                end
            end
            S_REPORT: begin
                if (bus.resp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_word       <= '0;
            r_idx        <= '0;
            r_hist       <= '0;
            r_count      <= '0;
            r_last_grant <= 1'b1;
            r_resp_id    <= 1'b0;
`ifdef PATTERN_FIRST_POS_EN
            r_first_pos  <= '0;
            r_found      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_word       <= w_grant1 ? bus.req1_data : bus.req0_data;
                        r_resp_id    <= w_grant1;
                        r_last_grant <= w_grant1;
                        r_idx        <= C_IDX_LAST;
                        r_hist       <= '0;
                        r_count      <= '0;
`ifdef PATTERN_FIRST_POS_EN
                        r_first_pos  <= '0;
                        r_found      <= 1'b0;
`endif
                    end
                end
                S_SHIFT: begin
                    r_hist <= w_window[PAT_W-2:0];
                    if (r_idx != '0) begin
                        r_idx <= r_idx - 1'b1;
                    end
                    if (w_match) begin
                        if (r_count != C_CNT_MAX) begin
                            r_count <= r_count + 1'b1;
                        end
`ifdef PATTERN_FIRST_POS_EN
                        // Position counts from the MSB, so it mirrors the bit index.
                        if (!r_found) begin
                            r_found     <= 1'b1;
                            r_first_pos <= C_IDX_LAST - r_idx;
                        end
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req0_ready = (r_state == S_IDLE) && w_grant0;
    assign bus.req1_ready = (r_state == S_IDLE) && w_grant1;
    assign bus.resp_valid = (r_state == S_REPORT);
    assign bus.resp_id    = (r_state == S_REPORT) ? r_resp_id : 1'b0;
    assign bus.resp_count = (r_state == S_REPORT) ? r_count : '0;
`ifdef PATTERN_FIRST_POS_EN
    assign bus.resp_first_pos = (r_state == S_REPORT) ? r_first_pos : '0;
    assign bus.resp_none      = (r_state == S_REPORT) && !r_found;
`endif

    assign busy        = (r_state != S_IDLE);
    assign ser_bit     = w_ser_bit;
    assign match_pulse = w_match;

endmodule

`default_nettype wire

// File: tb/tb_pattern_scan_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pattern_scan_arbiter
// Description : Directed and randomized self-checking bench for
//               pattern_scan_arbiter, including a CNT_W=1 saturation instance.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps

module tb_pattern_scan_arbiter;

    localparam int               DATA_W  = 8;
    localparam int               PAT_W   = 4;
    localparam int               CNT_W   = 4;
    localparam logic [PAT_W-1:0] PATTERN = 4'b1011;

    logic clk = 1'b0;
    logic reset_n;
    logic busy, ser_bit, match_pulse;
    logic busy_s, ser_bit_s, match_pulse_s;

    int errors = 0;
    int checks = 0;
    bit last_grant_m;

    always #5 clk = ~clk;

    pattern_scan_arbiter_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();
    pattern_scan_arbiter_if #(.DATA_W(DATA_W), .CNT_W(1))     bus_s ();

    pattern_scan_arbiter #(
        .DATA_W(DATA_W), .PAT_W(PAT_W), .PATTERN(PATTERN), .CNT_W(CNT_W)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .busy(busy), .ser_bit(ser_bit), .match_pulse(match_pulse)
    );

    pattern_scan_arbiter #(
        .DATA_W(DATA_W), .PAT_W(PAT_W), .PATTERN(PATTERN), .CNT_W(1)
    ) u_dut_sat (
        .clk(clk), .reset_n(reset_n), .bus(bus_s),
        .busy(busy_s), .ser_bit(ser_bit_s), .match_pulse(match_pulse_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: a match ends at MSB-relative position p when the PAT_W bits
    // ending there equal PATTERN and a full PAT_W bits have been seen.
    function automatic bit m_hit(input logic [DATA_W-1:0] w, input int p);
        logic [DATA_W-1:0] sh;
        if (p < PAT_W - 1) return 1'b0;
        sh = w >> (DATA_W - 1 - p);
        return sh[PAT_W-1:0] == PATTERN;
    endfunction

    function automatic int m_count(input logic [DATA_W-1:0] w, input int cmax);
        int n = 0;
        for (int p = 0; p < DATA_W; p++)
            if (m_hit(w, p) && n < cmax) n++;
        return n;
    endfunction

    function automatic int m_first(input logic [DATA_W-1:0] w);
        for (int p = 0; p < DATA_W; p++)
            if (m_hit(w, p)) return p;
        return 0;
    endfunction

    // Called at a negedge with the DUT idle; returns at the idle negedge after the response.
    task automatic do_job(input bit v0, input bit v1, input logic [DATA_W-1:0] d0,
                          input logic [DATA_W-1:0] d1, input int stall);
        bit g1;
        logic [DATA_W-1:0] w;
        if (v0 && v1) g1 = (last_grant_m == 1'b0);
        else          g1 = v1;
        w = g1 ? d1 : d0;
        last_grant_m = g1;

        bus.req0_valid = v0; bus.req0_data = d0;
        bus.req1_valid = v1; bus.req1_data = d1;
        bus.resp_ready = 1'b0;
        #1;
        check("req0_ready_grant", bus.req0_ready, !g1);
        check("req1_ready_grant", bus.req1_ready, g1);
        @(negedge clk);
        if (g1) bus.req1_valid = 1'b0;
        else    bus.req0_valid = 1'b0;

        for (int p = 0; p < DATA_W; p++) begin
            check("busy_shift", busy, 1'b1);
            check("ser_bit", ser_bit, w[DATA_W-1-p]);
            check("match_pulse", match_pulse, m_hit(w, p));
            check("ready_shift", {bus.req1_ready, bus.req0_ready}, 2'b00);
            check("resp_valid_shift", bus.resp_valid, 1'b0);
            @(negedge clk);
        end

        for (int s = 0; s <= stall; s++) begin
            check("resp_valid", bus.resp_valid, 1'b1);
            check("resp_id", bus.resp_id, g1);
            check("resp_count", bus.resp_count, m_count(w, (1 << CNT_W) - 1));
            check("ready_report", {bus.req1_ready, bus.req0_ready}, 2'b00);
`ifdef PATTERN_FIRST_POS_EN
            check("resp_first_pos", bus.resp_first_pos, m_first(w));
            check("resp_none", bus.resp_none, m_count(w, DATA_W) == 0);
`endif
            if (s == stall) bus.resp_ready = 1'b1;
            @(negedge clk);
        end
        bus.resp_ready = 1'b0;
        check("resp_valid_clear", bus.resp_valid, 1'b0);
        check("resp_count_clear", bus.resp_count, '0);
        check("busy_idle", busy, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_data = '0;
        bus.resp_ready = 1'b0;
        bus_s.req0_valid = 1'b0; bus_s.req0_data = '0;
        bus_s.req1_valid = 1'b0; bus_s.req1_data = '0;
        bus_s.resp_ready = 1'b0;
        last_grant_m = 1'b1;

        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_resp_valid", bus.resp_valid, 1'b0);
        check("rst_resp_id", bus.resp_id, 1'b0);
        check("rst_resp_count", bus.resp_count, '0);
        check("rst_match", match_pulse, 1'b0);
        check("rst_ser_bit", ser_bit, 1'b0);
        check("rst_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
`ifdef PATTERN_FIRST_POS_EN
        check("rst_first_pos", bus.resp_first_pos, '0);
        check("rst_none", bus.resp_none, 1'b0);
`endif
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed jobs: single requesters, tie, stalled report, tie again
        do_job(1'b1, 1'b0, 8'b1011_0110, 8'h00, 0);
        do_job(1'b0, 1'b1, 8'h00, 8'hFF, 1);
        do_job(1'b1, 1'b1, 8'b1011_1011, 8'b1011_1011, 0);
        do_job(1'b1, 1'b1, 8'b1011_1011, 8'b1011_1011, 5);
        do_job(1'b1, 1'b1, 8'b1101_1010, 8'b0101_1011, 0);

        // Randomized jobs
        for (int j = 0; j < 16; j++) begin
            int vm;
            vm = int'($urandom_range(1, 3));
            do_job(vm[0], vm[1], DATA_W'($urandom), DATA_W'($urandom),
                   int'($urandom_range(0, 3)));
        end

        // Reset in the middle of a job served to requester 0
        bus.req0_valid = 1'b1; bus.req0_data = 8'b1011_1011;
        bus.req1_valid = 1'b0;
        #1;
        check("midrst_ready0", bus.req0_ready, 1'b1);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_busy_before", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_match", match_pulse, 1'b0);
        check("midrst_resp_valid", bus.resp_valid, 1'b0);
        check("midrst_ser_bit", ser_bit, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        last_grant_m = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("midrst_no_resp", bus.resp_valid, 1'b0);
        end
        do_job(1'b1, 1'b1, 8'b0010_1100, 8'b1111_0000, 0);

        // One-bit counter saturates at 1
        bus_s.req0_valid = 1'b1; bus_s.req0_data = 8'b1011_1011;
        bus_s.resp_ready = 1'b1;
        #1;
        check("sat_ready0", bus_s.req0_ready, 1'b1);
        @(negedge clk);
        bus_s.req0_valid = 1'b0;
        repeat (DATA_W) @(negedge clk);
        check("sat_resp_valid", bus_s.resp_valid, 1'b1);
        check("sat_resp_count", bus_s.resp_count, m_count(8'b1011_1011, 1));
        @(negedge clk);
        check("sat_resp_clear", bus_s.resp_valid, 1'b0);
        bus_s.resp_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
